// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), position type and the
// registered output bundle used by the sync generator.
package vga_sync_gen_pkg;

  localparam int POS_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    pos_t x;
    pos_t y;
    logic strobe;
    logic line_start;
    logic frame_start;
  } sync_out_t;

  function automatic logic in_window(input pos_t v, input int lo, input int hi);
    return (v >= pos_t'(lo)) && (v <= pos_t'(hi));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: modulo-TOTAL counter holding the next coordinate to present,
// with a wrap flag and combinational visible/sync-window decode of that coordinate.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int VISIBLE    = DEF_H_VISIBLE,
  parameter int SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
  parameter int SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic adv_i,
  output pos_t cnt_o,
  output logic wrap_o,
  output logic visible_o,
  output logic in_sync_o
);

  pos_t cnt_q, cnt_d;

  assign wrap_o    = adv_i && (cnt_q == pos_t'(TOTAL - 1));
  assign visible_o = (cnt_q < pos_t'(VISIBLE));
  assign in_sync_o = in_window(cnt_q, SYNC_START, SYNC_END);
  assign cnt_o     = cnt_q;

  // Next coordinate: clear dominates, then wrap, then advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + pos_t'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical axis counters
// and a registered output stage presenting sync, visible flag, position and pulses.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   CLK_DIV   = 4,
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             videoOn,
  output logic [POS_W-1:0] widthVgaPos,
  output logic [POS_W-1:0] heightVgaPos,
  output logic             pixelStrobe,
  output logic             lineStart,
  output logic             frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam sync_out_t IDLE_OUT = '{
    hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b0,
    x: '0, y: '0, strobe: 1'b0, line_start: 1'b0, frame_start: 1'b0
  };

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s;
  pos_t             h_cnt_s, v_cnt_s;
  logic             h_wrap_s, v_wrap_s;
  logic             h_vis_s, v_vis_s, h_sync_s, v_sync_s;
  sync_out_t        out_q, out_d;

  assign tick_s = enable && (div_q == DIV_W'(CLK_DIV - 1));

  // Pixel-rate divider; held at zero while disabled so restart matches reset.
  always_comb begin
    div_d = div_q;
    if (!enable || tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC - 1)
  ) u_h_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!enable),
    .adv_i     (tick_s),
    .cnt_o     (h_cnt_s),
    .wrap_o    (h_wrap_s),
    .visible_o (h_vis_s),
    .in_sync_o (h_sync_s)
  );

  // The vertical axis steps once per completed line.
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC - 1)
  ) u_v_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!enable),
    .adv_i     (h_wrap_s),
    .cnt_o     (v_cnt_s),
    .wrap_o    (v_wrap_s),
    .visible_o (v_vis_s),
    .in_sync_o (v_sync_s)
  );

  // Output stage: present the decoded pixel on a tick, otherwise hold with pulses low.
  always_comb begin
    out_d             = out_q;
    out_d.strobe      = 1'b0;
    out_d.line_start  = 1'b0;
    out_d.frame_start = 1'b0;
    if (!enable) begin
      out_d = IDLE_OUT;
    end else if (tick_s) begin
      out_d.hsync       = h_sync_s ? SYNC_POL : ~SYNC_POL;
      out_d.vsync       = v_sync_s ? SYNC_POL : ~SYNC_POL;
      out_d.video_on    = h_vis_s && v_vis_s;
      out_d.x           = h_cnt_s;
      out_d.y           = v_cnt_s;
      out_d.strobe      = 1'b1;
      out_d.line_start  = (h_cnt_s == pos_t'(0));
      out_d.frame_start = (h_cnt_s == pos_t'(0)) && (v_cnt_s == pos_t'(0));
    end else begin
      out_d.x = out_q.x;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= IDLE_OUT;
    end else begin
      out_q <= out_d;
    end
  end

  assign hsync        = out_q.hsync;
  assign vsync        = out_q.vsync;
  assign videoOn      = out_q.video_on;
  assign widthVgaPos  = out_q.x;
  assign heightVgaPos = out_q.y;
  assign pixelStrobe  = out_q.strobe;
  assign lineStart    = out_q.line_start;
  assign frameStart   = out_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a reduced timing so whole frames,
// enable drops and asynchronous resets fit in a short run.
module tb_vga_sync_gen;

  localparam int CDIV = 3;
  localparam int HV = 10, HF = 2, HS = 3, HB = 2, HT = HV + HF + HS + HB;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2, VT = VV + VF + VS + VB;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       ps;
    logic       ls;
    logic       fs;
  } obs_t;

  localparam obs_t IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0, x: 10'd0, y: 10'd0,
                            ps: 1'b0, ls: 1'b0, fs: 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       hsync, vsync, videoOn, pixelStrobe, lineStart, frameStart;
  logic [9:0] widthVgaPos, heightVgaPos;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t hold_exp = IDLE;
  int   en_cnt = 0;
  int   pix = 0;

  vga_sync_gen #(
    .CLK_DIV(CDIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hsync(hsync), .vsync(vsync), .videoOn(videoOn),
    .widthVgaPos(widthVgaPos), .heightVgaPos(heightVgaPos),
    .pixelStrobe(pixelStrobe), .lineStart(lineStart), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  // Expected appearance of the p-th pixel since (re)start, straight from the timing rules.
  function automatic obs_t pix_obs(input int p);
    obs_t o;
    int   x, y;
    x    = p % HT;
    y    = (p / HT) % VT;
    o.hs = !((x >= HV + HF) && (x < HV + HF + HS));
    o.vs = !((y >= VV + VF) && (y < VV + VF + VS));
    o.von = (x < HV) && (y < VV);
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.ps = 1'b1;
    o.ls = (x == 0);
    o.fs = (x == 0) && (y == 0);
    return o;
  endfunction

  function automatic obs_t held(input obs_t o);
    obs_t h;
    h    = o;
    h.ps = 1'b0;
    h.ls = 1'b0;
    h.fs = 1'b0;
    return h;
  endfunction

  function automatic obs_t sample();
    return {hsync, vsync, videoOn, widthVgaPos, heightVgaPos, pixelStrobe, lineStart, frameStart};
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pixel every CDIV enabled clocks, restarting on reset or disable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      en_cnt   <= 0;
      pix      <= 0;
      hold_exp <= IDLE;
    end else if (!enable) begin
      en_cnt   <= 0;
      pix      <= 0;
      hold_exp <= IDLE;
    end else begin
      en_cnt <= en_cnt + 1;
      if ((en_cnt + 1) % CDIV == 0) begin
        exp_q.push_back(pix_obs(pix));
        hold_exp <= held(pix_obs(pix));
        pix      <= pix + 1;
      end
    end
  end

  // Monitor: every strobe consumes one expected pixel; between strobes outputs must hold.
  always @(negedge clk) begin
    if (pixelStrobe) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_strobe", 32'(pixelStrobe), 32'd0);
      end else begin
        check_val("pixel", 32'(sample()), 32'(exp_q.pop_front()));
      end
    end else begin
      if (exp_q.size() != 0) begin
        check_val("missing_strobe", 32'(pixelStrobe), 32'd1);
        exp_q.delete();
      end
      check_val("hold", 32'(sample()), 32'(hold_exp));
    end
  end

  task automatic wait_pix(input int x, input int y, input int budget);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = pixelStrobe && (widthVgaPos == 10'(x)) && (heightVgaPos == 10'(y));
    end
    check_val($sformatf("reach_%0d_%0d", x, y), 32'(hit), 32'd1);
  endtask

  // Called just after release of reset/enable: clocks until first strobe, which must be pixel (0,0).
  task automatic check_restart(input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4 * CDIV) begin
      @(posedge clk);
      n++;
      #1;
      seen = pixelStrobe;
    end
    check_val({name, "_latency"}, 32'(n), 32'(CDIV));
    check_val({name, "_first_pixel"}, 32'(sample()), 32'(pix_obs(0)));
  endtask

  task automatic frame_period();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameStart && n < 2 * HT * VT * CDIV);
    check_val("frame_period", 32'(n), 32'(HT * VT * CDIV));
  endtask

  initial begin
    int len, d;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state", 32'(sample()), 32'(IDLE));
    @(posedge clk);
    #2 rst_n = 1'b1;
    check_restart("reset_release");

    // Line wrap and a full frame.
    wait_pix(HT - 1, 0, 200);
    wait_pix(0, 1, 10);
    check_val("line_start", 32'({lineStart, frameStart}), 32'b10);
    wait_pix(HT - 1, VT - 1, 2000);
    wait_pix(0, 0, 10);
    check_val("frame_start", 32'(frameStart), 32'd1);
    frame_period();

    // Enable drop mid-frame.
    wait_pix(5, 3, 2000);
    @(posedge clk);
    #2 enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("disabled_idle", 32'(sample()), 32'(IDLE));
    #1 enable = 1'b1;
    check_restart("enable_restart");

    // Asynchronous reset while hsync is active.
    wait_pix(13, 2, 2000);
    @(posedge clk);
    #2;
    check_val("hsync_active", 32'(hsync), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("async_reset", 32'(sample()), 32'(IDLE));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check_restart("async_restart");

    // Random run lengths interleaved with enable drops and asynchronous resets.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(300, 20)) @(posedge clk);
      #2;
      len = $urandom_range(8, 1);
      case ($urandom_range(2, 0))
        0: begin
          enable = 1'b0;
          repeat (len) @(posedge clk);
          #2 enable = 1'b1;
        end
        1: begin
          d = $urandom_range(6, 0);
          if (d >= 3) d++;
          #(d) rst_n = 1'b0;
          repeat (len) @(posedge clk);
          #2 rst_n = 1'b1;
        end
        default: begin
          enable = 1'b1;
        end
      endcase
    end

    repeat (50) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
